// File: rtl/bulk_mem_arbiter.sv
// Round-robin arbiter sharing one bulk memory port among N_REQ requesters, with stall-hold
// and an in-order ID FIFO for response routing. Optional lock support: BULK_ARB_LOCK_EN.
module bulk_mem_arbiter #(
    parameter int N_REQ           = 2,
    parameter int DATA_W          = 64,
    parameter int ADDR_W          = 64,
    parameter int LINE_SIZE       = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic [N_REQ-1:0]                             i_req_valid,
    output logic [N_REQ-1:0]                             o_req_ready,
    input  logic [N_REQ-1:0][ADDR_W-1:0]                 i_req_addr,
    input  logic [N_REQ-1:0]                             i_req_write,
    input  logic [N_REQ-1:0][LINE_SIZE*DATA_W-1:0]       i_req_wdata,
    input  logic [N_REQ-1:0][LINE_SIZE*(DATA_W/8)-1:0]   i_req_wstrb,
    input  logic [N_REQ-1:0]                             i_req_lock,
    output logic [N_REQ-1:0]                             o_resp_valid,
    output logic [LINE_SIZE*DATA_W-1:0]                  o_resp_rdata,
    output logic                                         o_mem_req_valid,
    output logic [ADDR_W-1:0]                            o_mem_req_addr,
    output logic                                         o_mem_req_write,
    output logic [LINE_SIZE*DATA_W-1:0]                  o_mem_req_wdata,
    output logic [LINE_SIZE*(DATA_W/8)-1:0]              o_mem_req_wstrb,
    input  logic                                         i_mem_req_ready,
    input  logic                                         i_mem_resp_valid,
    input  logic [LINE_SIZE*DATA_W-1:0]                  i_mem_resp_rdata,
    output logic                                         o_resp_err
);

    localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int FP_W  = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = FP_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

    logic [ID_W-1:0]  r_rrPtr;
    logic             r_held;
    logic [ID_W-1:0]  r_heldId;
    logic [ID_W-1:0]  r_idFifo [MAX_OUTSTANDING];
    logic [FP_W-1:0]  r_head;
    logic [FP_W-1:0]  r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_respErr;

    logic             w_lockOwner;
    logic [ID_W-1:0]  w_lockId;
    logic             w_hasWinner;
    logic [ID_W-1:0]  w_winner;
    logic [ID_W:0]    w_scanIdx;
    logic             w_full;
    logic             w_memValid;
    logic             w_accept;
    logic             w_stall;
    logic             w_pop;
    logic [ID_W-1:0]  w_nextPtr;

`ifdef BULK_ARB_LOCK_EN
    logic             r_lockOwner;
    logic [ID_W-1:0]  r_lockId;

    // Lock release is evaluated first so that a fresh locked accept wins in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lockOwner <= 1'b0;
            r_lockId    <= '0;
        end else begin
            if (r_lockOwner && !i_req_lock[r_lockId]) begin
                r_lockOwner <= 1'b0;
            end
            if (w_accept && i_req_lock[w_winner]) begin
                r_lockOwner <= 1'b1;
                r_lockId    <= w_winner;
            end
        end
    end

    assign w_lockOwner = r_lockOwner;
    assign w_lockId    = r_lockId;
`else
    logic w_unusedLock;
    assign w_unusedLock = ^i_req_lock;
    assign w_lockOwner  = 1'b0;
    assign w_lockId     = '0;
`endif

    // Scan from the highest offset down so the requester closest to r_rrPtr wins last.
    always_comb begin
        w_hasWinner = 1'b0;
        w_winner    = '0;
        w_scanIdx   = '0;
        if (r_held) begin
            w_hasWinner = 1'b1;
            w_winner    = r_heldId;
        end else if (w_lockOwner) begin
            w_hasWinner = i_req_valid[w_lockId];
            w_winner    = w_lockId;
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                w_scanIdx = {1'b0, r_rrPtr} + (ID_W + 1)'(i);
                if (w_scanIdx >= (ID_W + 1)'(N_REQ)) begin
                    w_scanIdx = w_scanIdx - (ID_W + 1)'(N_REQ);
                end
                if (i_req_valid[w_scanIdx[ID_W-1:0]]) begin
                    w_hasWinner = 1'b1;
                    w_winner    = w_scanIdx[ID_W-1:0];
                end
            end
        end
    end

    assign w_full     = (r_count == FULL_CNT);
    assign w_memValid = w_hasWinner && !w_full && !rst;
    assign w_accept   = w_memValid && i_mem_req_ready;
    assign w_stall    = w_memValid && !i_mem_req_ready;
    assign w_pop      = i_mem_resp_valid && (r_count != '0) && !rst;
    assign w_nextPtr  = (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + ID_W'(1);

    always_comb begin
        o_mem_req_valid = w_memValid;
        o_mem_req_addr  = '0;
        o_mem_req_write = 1'b0;
        o_mem_req_wdata = '0;
        o_mem_req_wstrb = '0;
        o_req_ready     = '0;
        o_resp_valid    = '0;
        if (w_hasWinner && !rst) begin
            o_mem_req_addr  = i_req_addr[w_winner];
            o_mem_req_write = i_req_write[w_winner];
            o_mem_req_wdata = i_req_wdata[w_winner];
            o_mem_req_wstrb = i_req_wstrb[w_winner];
            o_req_ready[w_winner] = i_mem_req_ready && !w_full;
        end
        if (w_pop) begin
            o_resp_valid[r_idFifo[r_head]] = 1'b1;
        end
    end

    assign o_resp_rdata = i_mem_resp_rdata;
    assign o_resp_err   = r_respErr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rrPtr  <= '0;
            r_held   <= 1'b0;
            r_heldId <= '0;
        end else if (w_accept) begin
            r_rrPtr <= w_nextPtr;
            r_held  <= 1'b0;
        end else if (w_stall) begin
            r_held   <= 1'b1;
            r_heldId <= w_winner;
        end
    end

    // A response with nothing outstanding is dropped and flagged stickily.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_respErr <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tail <= r_tail + FP_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + FP_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (i_mem_resp_valid && (r_count == '0)) begin
                r_respErr <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_idFifo[r_tail] <= w_winner;
        end
    end

endmodule
